// File: rtl/qspi_flash_responder.sv
`default_nettype none
// ============================================================================
// Module : qspi_flash_responder
// Brief  : SPI mode-0 flash emulator serving READ (0x03) and JEDEC ID (0x9F)
//          from a synchronous byte-wide memory read port.
// Rev    : 1.0
// ============================================================================
module qspi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4017
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam logic [7:0]        c_OP_READ  = 8'h03;
  localparam logic [7:0]        c_OP_ID    = 8'h9F;
  localparam logic [ADDR_W-1:0] c_ADDR_ONE = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CMD    = 3'd1,
    S_ADDR   = 3'd2,
    S_DATA   = 3'd3,
    S_ID     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  logic [1:0] r_sck_sync;
  logic [1:0] r_cs_sync;
  logic [1:0] r_mosi_sync;
  logic       r_sck_prev;

  logic w_sck;
  logic w_cs_n;
  logic w_mosi;
  logic w_rise;
  logic w_fall;

  assign w_sck  = r_sck_sync[1];
  assign w_cs_n = r_cs_sync[1];
  assign w_mosi = r_mosi_sync[1];
  assign w_rise = w_sck & ~r_sck_prev;
  assign w_fall = ~w_sck & r_sck_prev;

  // cs_n synchronizer resets to deselected so no frame starts out of reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_sck_sync  <= 2'b00;
      r_cs_sync   <= 2'b11;
      r_mosi_sync <= 2'b00;
      r_sck_prev  <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[0], spi_sck};
      r_cs_sync   <= {r_cs_sync[0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[0], spi_mosi};
      r_sck_prev  <= w_sck;
    end
  end

  state_t            r_state;
  logic [4:0]        r_bit;
  logic [23:0]       r_shift;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_pref;
  logic [7:0]        r_dout;
  logic              r_cap;
  logic              r_miso;
  logic              r_oe;
  logic              r_req;
  logic              r_err;

  logic [23:0] w_addr_in;
  logic [7:0]  w_op;

  assign w_addr_in = {r_shift[22:0], w_mosi};
  assign w_op      = {r_shift[6:0], w_mosi};

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bit   <= 5'd0;
      r_shift <= 24'd0;
      r_addr  <= '0;
      r_pref  <= 8'd0;
      r_dout  <= 8'd0;
      r_cap   <= 1'b0;
      r_miso  <= 1'b0;
      r_oe    <= 1'b0;
      r_req   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_req <= 1'b0;
      r_err <= 1'b0;
      // read data is valid one cycle after the strobe, so capture a cycle later
      r_cap <= r_req;
      if (r_cap) begin
        r_pref <= mem_rdata;
      end
      if (w_cs_n) begin
        r_state <= S_IDLE;
        r_bit   <= 5'd0;
        r_miso  <= 1'b0;
        r_oe    <= 1'b0;
        r_cap   <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state <= S_CMD;
            r_bit   <= 5'd0;
          end
          S_CMD: begin
            if (w_rise) begin
              r_shift <= {r_shift[22:0], w_mosi};
              r_bit   <= r_bit + 5'd1;
              if (r_bit == 5'd7) begin
                r_bit <= 5'd0;
                if (w_op == c_OP_READ) begin
                  r_state <= S_ADDR;
                end else if (w_op == c_OP_ID) begin
                  r_state <= S_ID;
                  r_shift <= JEDEC_ID;
                  r_oe    <= 1'b1;
                end else begin
                  r_state <= S_IGNORE;
                  r_err   <= 1'b1;
                end
              end
            end
          end
          S_ADDR: begin
            if (w_rise) begin
              r_shift <= w_addr_in;
              r_bit   <= r_bit + 5'd1;
              if (r_bit == 5'd23) begin
                r_bit   <= 5'd0;
                r_addr  <= w_addr_in[ADDR_W-1:0];
                r_req   <= 1'b1;
                r_state <= S_DATA;
                r_oe    <= 1'b1;
              end
            end
          end
          S_DATA: begin
            if (w_fall) begin
              if (r_bit == 5'd0) begin
                r_miso <= r_pref[7];
                r_dout <= {r_pref[6:0], 1'b0};
              end else begin
                r_miso <= r_dout[7];
                r_dout <= {r_dout[6:0], 1'b0};
              end
            end
            if (w_rise) begin
              if (r_bit == 5'd7) begin
                r_bit  <= 5'd0;
                r_addr <= r_addr + c_ADDR_ONE;
                r_req  <= 1'b1;
              end else begin
                r_bit <= r_bit + 5'd1;
              end
            end
          end
          S_ID: begin
            // zeros shift in behind the ID, so MISO idles low after byte three
            if (w_fall) begin
              r_miso  <= r_shift[23];
              r_shift <= {r_shift[22:0], 1'b0};
            end
          end
          S_IGNORE: begin
            r_miso <= 1'b0;
            r_oe   <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_oe;
  assign mem_req     = r_req;
  assign mem_addr    = r_addr;
  assign cmd_err     = r_err;
  assign busy        = (r_state != S_IDLE);

endmodule
`default_nettype wire
